// File: rtl/irrigation_pkg.sv
// irrigation_pkg
// Shared types and constants for the irrigation sequencer:
//   state_t             - sequencer state encoding
//   DEF_SETTLE_TICKS    - default OPEN/CLOSE duration in ticks
//   DEF_LOCKOUT_TICKS   - default LOCKOUT duration in ticks
//   cnt_width()         - width of the tick down-counter
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_WATER,
        ST_CLOSE,
        ST_LOCKOUT
    } state_t;

    localparam int unsigned DEF_SETTLE_TICKS  = 2;
    localparam int unsigned DEF_LOCKOUT_TICKS = 4;

    // Counter must hold the widest of: the duration input, the settle
    // constant and the lockout constant.
    function automatic int unsigned cnt_width(input int unsigned dur_w,
                                              input int unsigned settle,
                                              input int unsigned lockout);
        int unsigned mx;
        int unsigned w;
        mx = (settle > lockout) ? settle : lockout;
        w  = $clog2(mx + 1);
        if (w < 1)
            w = 1;
        return (dur_w > w) ? dur_w : w;
    endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// irrigation_sequencer_if
// Bundles the request/sensor inputs and the valve/pump/status outputs.
//   start, dur, soil_dry, tank_low, abort : requester/sensors -> sequencer
//   valve, pump, busy, done, alarm, tick  : sequencer -> drivers/status
// master: request/sensor side; slave: the sequencer.
interface irrigation_sequencer_if #(
    parameter int unsigned DUR_W = 8
);
    logic             start;
    logic [DUR_W-1:0] dur;
    logic             soil_dry;
    logic             tank_low;
    logic             abort;
    logic             valve;
    logic             pump;
    logic             busy;
    logic             done;
    logic             alarm;
    logic             tick;

    modport master (
        output start, dur, soil_dry, tank_low, abort,
        input  valve, pump, busy, done, alarm, tick
    );

    modport slave (
        input  start, dur, soil_dry, tank_low, abort,
        output valve, pump, busy, done, alarm, tick
    );
endinterface

// File: rtl/irrigation_sequencer_tick_timer.sv
// tick_timer
// Single-clock prescaler producing a tick enable every 2^DIV_BITS cycles,
// plus a loadable tick down-counter.
//   clk, rst  : system clock, synchronous active-high reset
//   clear     : state transition; zero the prescaler and load load_val
//   load_val  : tick count for the state being entered
//   tick      : prescaler at all-ones (one cycle per period)
//   expired   : the final tick of the loaded count is occurring now
module tick_timer #(
    parameter int unsigned DIV_BITS = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             expired
);

    logic [DIV_BITS-1:0] presc;
    logic [CNT_W-1:0]    count;

    assign tick = &presc;
    // Flagging the last tick (count==1) lets the FSM leave on that very
    // edge, so a state of N ticks spans exactly N prescaler periods.
    assign expired = tick && (count <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
        end else if (clear) begin
            presc <= '0;
            count <= load_val;
        end else begin
            presc <= presc + DIV_BITS'(1);
            if (tick && (count != '0))
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer
// Sequences one irrigation cycle: valve settle (OPEN), pump-on watering
// (WATER), valve close settle (CLOSE), then a minimum-off LOCKOUT.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : irrigation_sequencer_if.slave
//          in : start, dur, soil_dry, tank_low, abort
//          out: valve, pump, busy, done, alarm, tick (all registered)
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned DIV_BITS      = 16,
    parameter int unsigned DUR_W         = 8,
    parameter int unsigned SETTLE_TICKS  = DEF_SETTLE_TICKS,
    parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
    input logic                    clk,
    input logic                    rst,
    irrigation_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(DUR_W, SETTLE_TICKS, LOCKOUT_TICKS);

    state_t           state;
    state_t           nxt;
    logic [DUR_W-1:0] dur_q;
    logic [CNT_W-1:0] load_val;
    logic             go;
    logic             set_alarm;
    logic             set_flag;
    logic             clr_flag;
    logic             flag;
    logic             tick;
    logic             expired;
    logic             valve_q;
    logic             pump_q;
    logic             busy_q;
    logic             done_q;
    logic             alarm_q;

    tick_timer #(
        .DIV_BITS (DIV_BITS),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (go),
        .load_val (load_val),
        .tick     (tick),
        .expired  (expired)
    );

    // Next-state decode is combinational because the timer must be
    // cleared and reloaded on the same edge the state changes.
    always_comb begin
        nxt       = state;
        set_alarm = 1'b0;
        set_flag  = 1'b0;
        clr_flag  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.tank_low)
                        set_alarm = 1'b1;
                    else if (bus.soil_dry && (bus.dur != '0)) begin
                        nxt      = ST_OPEN;
                        clr_flag = 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (bus.tank_low) begin
                    nxt       = ST_CLOSE;
                    set_alarm = 1'b1;
                    clr_flag  = 1'b1;
                end else if (bus.abort) begin
                    nxt      = ST_CLOSE;
                    clr_flag = 1'b1;
                end else if (expired)
                    nxt = ST_WATER;
            end
            ST_WATER: begin
                if (bus.tank_low) begin
                    nxt       = ST_CLOSE;
                    set_alarm = 1'b1;
                    clr_flag  = 1'b1;
                end else if (bus.abort) begin
                    nxt      = ST_CLOSE;
                    clr_flag = 1'b1;
                end else if (!bus.soil_dry || expired) begin
                    nxt      = ST_CLOSE;
                    set_flag = 1'b1;
                end
            end
            ST_CLOSE: begin
                if (expired)
                    nxt = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (expired)
                    nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase

        go = (nxt != state);

        case (nxt)
            ST_OPEN, ST_CLOSE: load_val = CNT_W'(SETTLE_TICKS);
            ST_WATER:          load_val = CNT_W'(dur_q);
            ST_LOCKOUT:        load_val = CNT_W'(LOCKOUT_TICKS);
            default:           load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            dur_q   <= '0;
            flag    <= 1'b0;
            valve_q <= 1'b0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= 1'b0;

            if ((state == ST_IDLE) && (nxt == ST_OPEN)) begin
                dur_q   <= bus.dur;
                alarm_q <= 1'b0;
            end
            if (set_alarm)
                alarm_q <= 1'b1;

            if (clr_flag)
                flag <= 1'b0;
            else if (set_flag)
                flag <= 1'b1;

            if ((state == ST_LOCKOUT) && (nxt == ST_IDLE))
                done_q <= flag;

            valve_q <= (nxt == ST_OPEN) || (nxt == ST_WATER) || (nxt == ST_CLOSE);
            pump_q  <= (nxt == ST_WATER);
            busy_q  <= (nxt != ST_IDLE);
        end
    end

    assign bus.valve = valve_q;
    assign bus.pump  = pump_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.alarm = alarm_q;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb_irrigation_sequencer
// Directed scenarios with per-cycle expectations pushed into a scoreboard
// queue; a monitor compares DUT outputs against the queue on each falling
// edge. Spec cycle n of a scenario maps to bench cycle base+n.
module tb_irrigation_sequencer;

    localparam int TPT = 4;  // clk cycles per tick with DIV_BITS=2

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irrigation_sequencer_if #(.DUR_W(8)) bus ();

    irrigation_sequencer #(
        .DIV_BITS      (2),
        .DUR_W         (8),
        .SETTLE_TICKS  (2),
        .LOCKOUT_TICKS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // exp bits: {valve, pump, busy, done, alarm, tick}
    typedef struct {
        int         cyc;
        int         n;
        string      nm;
        logic [5:0] exp;
        bit         tchk;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   base     = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit inw(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    // tmode: 0 = ignore tick, 1 = tick every TPT cycles inside busy window,
    // 2 = tick must be 0
    task automatic sched(input string nm, input int len,
                         input int vl, input int vh, input int pl, input int ph,
                         input int bl, input int bh, input int da,
                         input int al, input int ah, input int tmode);
        for (int n = 0; n < len; n++) begin
            exp_t e;
            e.cyc  = base + n;
            e.n    = n;
            e.nm   = nm;
            e.exp  = {inw(n, vl, vh), inw(n, pl, ph), inw(n, bl, bh), (n == da),
                      inw(n, al, ah), (tmode == 1) && inw(n, bl, bh) && ((n % TPT) == 0)};
            e.tchk = (tmode == 2) || ((tmode == 1) && inw(n, bl, bh));
            sbq.push_back(e);
        end
    endtask

    task automatic arm();
        @(negedge clk);
        base = cyc + 1;
    endtask

    task automatic fire(input logic [7:0] d, input bit hold);
        @(negedge clk);
        bus.dur   = d;
        bus.start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic at(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sbq.size() > 0) && (guard < 3000)) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [5:0] got;
        logic [5:0] mask;
        forever begin
            @(negedge clk);
            while ((sbq.size() > 0) && (sbq[0].cyc <= cyc)) begin
                e    = sbq.pop_front();
                got  = {bus.valve, bus.pump, bus.busy, bus.done, bus.alarm, bus.tick};
                mask = e.tchk ? 6'b111111 : 6'b111110;
                checks++;
                if (e.cyc < cyc) begin
                    failures++;
                    $display("FAIL %s n=%0d not sampled: scheduled cyc %0d, now %0d",
                             e.nm, e.n, e.cyc, cyc);
                end else if ((got & mask) !== (e.exp & mask)) begin
                    failures++;
                    $display("FAIL %s n=%0d {valve,pump,busy,done,alarm,tick} got=%b required=%b",
                             e.nm, e.n, got & mask, e.exp & mask);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        bus.start    = 1'b0;
        bus.dur      = '0;
        bus.soil_dry = 1'b1;
        bus.tank_low = 1'b0;
        bus.abort    = 1'b0;
        rst          = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        arm();
        sched("reset", 2, -1, -1, -1, -1, -1, -1, -1, -1, -1, 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain();

        // Normal cycle, dur=3
        arm();
        sched("normal", 48, 1, 28, 9, 20, 1, 44, 45, -1, -1, 1);
        fire(8'd3, 1'b0);
        drain();

        // Tank fault during WATER
        arm();
        sched("tank", 40, 1, 20, 9, 12, 1, 36, -1, 13, 39, 1);
        fire(8'd3, 1'b0);
        at(12); bus.tank_low = 1'b1;
        at(13); bus.tank_low = 1'b0;
        drain();

        // Valid start clears the alarm
        arm();
        sched("after_tank", 48, 1, 28, 9, 20, 1, 44, 45, 0, 0, 1);
        fire(8'd3, 1'b0);
        drain();

        // Abort and tank_low together in OPEN
        arm();
        sched("abort_tank", 32, 1, 11, -1, -1, 1, 27, -1, 4, 31, 0);
        fire(8'd3, 1'b0);
        at(3); bus.abort = 1'b1; bus.tank_low = 1'b1;
        at(4); bus.abort = 1'b0; bus.tank_low = 1'b0;
        drain();

        // Soil turns wet during WATER
        arm();
        sched("soil_wet", 38, 1, 18, 9, 10, 1, 34, 35, 0, 0, 0);
        fire(8'd200, 1'b0);
        at(10); bus.soil_dry = 1'b0;
        at(12); bus.soil_dry = 1'b1;
        drain();

        // Ignored starts: dur=0, then soil wet
        arm();
        sched("ignored", 8, -1, -1, -1, -1, -1, -1, -1, -1, -1, 0);
        fire(8'd0, 1'b1);
        at(3); bus.dur = 8'd5; bus.soil_dry = 1'b0;
        at(6); bus.start = 1'b0; bus.soil_dry = 1'b1;
        drain();

        // Start held while busy, dur changed mid-run: neither has effect
        arm();
        sched("busy_start", 42, 1, 20, 9, 12, 1, 36, 37, -1, -1, 1);
        fire(8'd1, 1'b1);
        at(2);  bus.dur = 8'd50;
        at(31); bus.start = 1'b0;
        drain();

        // Start with tank_low in IDLE
        arm();
        sched("tank_idle", 4, -1, -1, -1, -1, -1, -1, -1, 1, 3, 0);
        bus.tank_low = 1'b1;
        fire(8'd3, 1'b0);
        bus.tank_low = 1'b0;
        drain();

        // Reset mid-WATER, then a fresh normal run
        arm();
        sched("rst_water", 15, 1, 12, 9, 12, 1, 12, -1, 0, 0, 1);
        fire(8'd3, 1'b0);
        at(12); rst = 1'b1;
        at(13); rst = 1'b0;
        arm();
        sched("post_rst", 48, 1, 28, 9, 20, 1, 44, 45, -1, -1, 1);
        fire(8'd3, 1'b0);
        drain();

        // Maximum duration
        arm();
        sched("dur_max", 1056, 1, 1036, 9, 1028, 1, 1052, 1053, -1, -1, 1);
        fire(8'hFF, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
